// File: rtl/cla_nibble_seq_ctrl.sv
// cla_nibble_seq_ctrl: WIDTH-bit adder built from one 4-bit carry look-ahead
// slice, stepped one nibble per clock from the least-significant nibble up.
// The carry between nibbles is held in a register. Operands are captured on
// accept, and the result is reported with a one-cycle done pulse.

// Purely combinational 4-bit carry look-ahead slice. c3 is the carry into
// bit 3, which is needed to compute signed overflow on the top nibble.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p  = x ^ y;
  assign g  = x & y;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = p ^ {c3, c2, c1, ci};
endmodule

module cla_nibble_seq_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v
);
  // A single-nibble adder still needs a 1-bit index so the vectors stay legal.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               v_q, v_d;

  logic [3:0]         slice_x;
  logic [3:0]         slice_y;
  logic [3:0]         slice_s;
  logic               slice_co;
  logic               slice_c3;

  // The slice always looks at the nibble selected by the current index.
  assign slice_x = a_q[4*idx_q +: 4];
  assign slice_y = b_q[4*idx_q +: 4];

  cla4_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // Next-state logic: accept in IDLE/DONE, one nibble per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          sum_d   = '0;
          c_out_d = 1'b0;
          v_d     = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately ignored here; operands stay as captured.
        sum_d[4*idx_q +: 4] = slice_s;
        carry_d             = slice_co;
        idx_d               = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          c_out_d = slice_co;
          v_d     = slice_c3 ^ slice_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      v_q     <= v_d;
    end
  end

  // Status is a decode of the state register only, so no input reaches an output.
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign v     = v_q;

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Testbench for cla_nibble_seq_ctrl (NIBBLES=4): directed cases plus random
// operations, checked against an arithmetic reference model.
module tb_cla_nibble_seq_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         v;

  int n_checks = 0;
  int n_errors = 0;

  cla_nibble_seq_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .v     (v)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the full operands.
  function automatic logic [18:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
    logic [W:0]   full;
    logic [W-1:0] low;
    logic         cmsb;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
    cmsb = low[W-1];
    ref_add = {full[W] ^ cmsb, full[W], full[W-1:0]}; // {v, c_out, sum}
  endfunction

  task automatic drive_start(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    a = xa; b = xb; c_in = xc; start = 1'b1;
  endtask

  // Called at the negedge right after the accept edge. Steps through RUN,
  // checks partial and final results, then either chains the next operation
  // (start held in DONE) or returns to IDLE.
  task automatic finish_op(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                           input bit noise, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    logic [18:0] r;
    logic [31:0] mask;
    r = ref_add(ea, eb, ec);
    check_val("accept_busy", 32'(busy), 32'd1);
    check_val("accept_done", 32'(done), 32'd0);
    check_val("accept_sum",  32'(sum),  32'd0);
    check_val("accept_cout", 32'(c_out), 32'd0);
    for (int i = 1; i <= N; i++) begin
      start = noise ? 1'(($urandom % 2)) : 1'b0;
      a = (noise && i == 1) ? 16'hAAAA : 16'($urandom);
      b = 16'($urandom);
      c_in = 1'($urandom % 2);
      if (noise && i == 1) start = 1'b1;
      @(negedge clk);
      if (i < N) begin
        mask = (32'd1 << (4 * i)) - 32'd1;
        check_val("run_busy", 32'(busy), 32'd1);
        check_val("run_done", 32'(done), 32'd0);
        check_val("run_sum",  32'(sum),  32'(r[W-1:0]) & mask);
      end else begin
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("done_busy",  32'(busy), 32'd0);
        check_val("sum",        32'(sum),  32'(r[W-1:0]));
        check_val("c_out",      32'(c_out), 32'(r[W]));
        check_val("v",          32'(v),    32'(r[W+1]));
      end
    end
    if (chain) drive_start(na, nb, nc);
    else begin
      start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    end
    @(negedge clk);
    check_val("post_done", 32'(done), 32'd0);
    if (chain) begin
      check_val("chain_busy", 32'(busy), 32'd1);
      check_val("chain_sum",  32'(sum),  32'd0);
    end else begin
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("hold_sum",  32'(sum),  32'(r[W-1:0]));
      check_val("hold_cout", 32'(c_out), 32'(r[W]));
      check_val("hold_v",    32'(v),    32'(r[W+1]));
    end
  endtask

  task automatic single_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input bit noise);
    drive_start(xa, xb, xc);
    @(negedge clk);
    finish_op(xa, xb, xc, noise, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_sum"},  32'(sum),  32'd0);
    check_val({tag, "_cout"}, 32'(c_out), 32'd0);
    check_val({tag, "_v"},    32'(v),    32'd0);
  endtask

  // Start an op, assert rst for two cycles at step 2, expect no done pulse.
  task automatic abort_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    drive_start(xa, xb, xc);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort_rst1");
    @(negedge clk);
    check_zero("abort_rst2");
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check_val("abort_no_done", 32'(done), 32'd0);
      check_val("abort_no_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ca, cb, xa, xb;
    logic         cc, xc;
    bit           ch;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    single_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    $display("basic add 0x1234+0x4321 done");
    single_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    $display("full carry ripple done");
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    $display("signed overflow 0x7FFF+1 done");
    single_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    $display("signed overflow 0x8000+0x8000 done");
    single_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
    $display("ignored start during RUN done");
    abort_op(16'h00FF, 16'h0001, 1'b0);
    $display("abort with reset at step 2 done");
    single_op(16'h0002, 16'h0003, 1'b0, 1'b0);
    $display("op after abort done");

    drive_start(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    finish_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h1000, 1'b0);
    finish_op(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    $display("back-to-back pair done");

    ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom % 2);
    drive_start(ca, cb, cc);
    @(negedge clk);
    for (int it = 0; it < 30; it++) begin
      xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom % 2);
      ch = (it < 29) && (($urandom % 2) == 1);
      finish_op(ca, cb, cc, 1'($urandom % 2), ch, xa, xb, xc);
      $display("random op %0d: a=0x%04h b=0x%04h cin=%0d chained_next=%0d", it, ca, cb, cc, ch);
      if (!ch && it < 29) begin
        if (($urandom % 5) == 0) begin
          abort_op(16'($urandom), 16'($urandom), 1'($urandom % 2));
          $display("random abort done");
        end
        drive_start(xa, xb, xc);
        @(negedge clk);
      end
      ca = xa; cb = xb; cc = xc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cla_nibble_seq_ctrl.md
# cla_nibble_seq_ctrl

Sequencing controller that performs a WIDTH-bit addition by time-multiplexing a single 4-bit carry look-ahead adder slice, one nibble per clock, least-significant nibble first. The inter-nibble carry is held in a register between steps. Operands are captured on a start/done handshake. The block sits between the operand source and result consumer and owns the only CLA slice on this path; the slice is instantiated internally as purely combinational logic.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit steps per addition; must be ≥ 1.
- WIDTH, 4*NIBBLES, operand and result width (derived; not overridden independently).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new addition; sampled on a rising edge.
- a  in  WIDTH  operand A; captured at accept.
- b  in  WIDTH  operand B; captured at accept.
- c_in  in  1  carry-in; captured at accept.
- busy  out  1  high while nibble steps are in progress (state RUN).
- done  out  1  one-cycle pulse; result is valid.
- sum  out  WIDTH  registered result.
- c_out  out  1  carry out of the MSB nibble.
- v  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, c_out=0, v=0. The nibble index, carry register and operand registers are also cleared.
- **Accept:** start=1 sampled in IDLE or DONE.
  - a, b and c_in are latched.
  - sum is cleared to 0, c_out and v are cleared to 0, index is set to 0.
  - Next state is RUN.
- **Ignored start:** start while in RUN is ignored. No re-latch, no error.
- **RUN step (each edge):**
  - The CLA slice adds nibble[idx] of A, nibble[idx] of B and the carry register.
  - The 4-bit result is written to sum[4*idx+3:4*idx]; the slice carry-out goes to the carry register.
  - idx increments.
- **Last step (idx = NIBBLES-1):**
  - c_out is written from the slice carry-out.
  - v is written as (carry into bit 3 of the slice) XOR (slice carry-out).
  - Next state is DONE.
- **DONE:** lasts exactly one cycle with done=1.
  - Next state is RUN if start=1, otherwise IDLE.
- Result outputs (sum, c_out, v) hold their value until the next accept or reset.
- Input changes on a, b, c_in while in RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. The carry-out of the final nibble is c_out, never written into sum.
- rst overrides everything in any state, including mid-RUN. The partial result is discarded and all outputs return to their reset values on that edge.
- NIBBLES=1: RUN lasts exactly one cycle.

## Timing
- Edge E0 accepts start. After E0: busy=1.
- Edges E1..E_NIBBLES perform the nibble steps; nibble k is written at edge E(k+1).
- After E_NIBBLES: busy=0, done=1, and sum/c_out/v are final.
- After E_NIBBLES+1: done=0.
- Latency from accept edge to done visible is NIBBLES edges. busy is high for exactly NIBBLES cycles.
- Maximum throughput is one addition per NIBBLES+1 cycles, achieved by holding start=1 so it is accepted in DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The critical path is one 4-bit CLA slice plus the carry register mux.

## Test plan
- **Reset:** assert rst for 2 cycles mid-random activity -> busy=0, done=0, sum=0x0000, c_out=0, v=0 on the first edge with rst=1.
- **Basic add:** a=0x1234, b=0x4321, c_in=0, start pulse -> busy high for 4 cycles, then done=1 for 1 cycle with sum=0x5555, c_out=0, v=0.
- **Full carry ripple:** a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, v=0. Intermediate sum nibbles read 0 after each step.
- **Signed overflow:** a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, v=1. Also a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, v=1.
- **Ignored start and abort:**
  - Start a=0x00FF, b=0x0001; then pulse start with a=0xAAAA during RUN and change a -> result sum=0x0100, done exactly once.
  - Repeat, asserting rst at step 2 -> outputs zero, no done pulse.
  - Next op a=0x0002, b=0x0003 -> sum=0x0005.
- **Back-to-back:** hold start=1 with a=0x0001, b=0x0001, then switch to a=0x1000, b=0x1000 in the DONE cycle -> first done with sum=0x0002. The second op is accepted at the DONE edge; its done arrives 5 cycles after the first with sum=0x2000, c_out=0.
